serial_adder: RTL and testbench

- Bit-serial N-bit adder built around the team's existing combinational full-adder cell `fulladder` (3-bit input `abc`, outputs `sum`, `carry`). This block is the stage directly upstream and downstream of that cell: it feeds `abc` and consumes `sum`/`carry`.
- Loads two operands and walks them LSB-first through one `fulladder` instance, one bit per clock, holding the carry in a flip-flop.
- Result is presented with a start/done handshake.
- Used wherever area matters more than latency.

---
 rtl/serial_adder.sv | 142 ++++++++++++++
 tb/tb_serial_adder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands walk LSB-first through one fulladder cell,
// with the carry held in a flop and a start/done handshake around the result.

module fulladder (
    input  logic [2:0] abc,
    output logic       sum,
    output logic       carry
);
    assign sum   = ^abc;
    assign carry = (abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0]);
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one bit per clock through the full adder, WIDTH cycles
// DONE  | one-cycle done pulse, result already registered
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] s_sh;
    logic [WIDTH-1:0] s_full;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_carry;

    fulladder u_fa (
        .abc   ({a_sh[0], b_sh[0], c_q}),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // s_sh holds the WIDTH-1 bits already produced; the bit in flight completes the word
    assign s_full   = {fa_sum, s_sh};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            RUN:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            c_q    <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        c_q  <= cin;
                        s_sh <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    s_sh <= s_full[WIDTH-1:1];
                    c_q  <= fa_carry;
                    if (last_bit) begin
                        cnt    <= '0;
                        sum_q  <= s_full;
                        cout_q <= fa_carry;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected sums are queued at issue and
// popped by an independent monitor whenever done is presented.

module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           done_cnt = 0;
    logic [W:0]   exp_q[$];
    logic [W:0]   model_result;
    logic         prev_done = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the oldest expected result on every done pulse
    always @(negedge clk) begin
        logic [W:0] e;
        if (rst_n && done) begin
            done_cnt++;
            check("done_one_cycle", 64'(prev_done), 64'(0));
            check("busy_with_done", 64'(busy), 64'(1));
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending add at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("result", 64'({cout, sum}), 64'(e));
            end
        end
        prev_done = rst_n && done;
    end

    // Called just after a negedge with the DUT idle; start is sampled at the next edge (edge 0)
    task automatic run_add(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                           input bit poke);
        logic [W:0]  e;
        int unsigned m;
        int unsigned s;
        e = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cc};
        a = aa;
        b = bb;
        cin = cc;
        start = 1'b1;
        exp_q.push_back(e);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            check("busy", 64'(busy), 64'(k <= W));
            check("done", 64'(done), 64'(k == W));
            if (k >= 1 && k <= W) begin
                m = (32'd1 << k) - 32'd1;
                s = (int'(aa) & m) + (int'(bb) & m) + int'(cc);
                check("carry_chain", 64'(dut.c_q), 64'((s >> k) & 32'd1));
            end
            if (k < W) check("sum_hold", 64'({cout, sum}), 64'(model_result));
            else       check("sum_new", 64'({cout, sum}), 64'(e));
            start = poke && (k == 2 || k == W);
            if (start) begin
                a = 8'hAA;
                b = 8'h55;
            end
        end
        model_result = e;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        model_result = '0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));

        run_add(8'h35, 8'h4A, 1'b0, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, 1'b0);
        run_add(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_add(8'h00, 8'h00, 1'b0, 1'b0);
        run_add(8'h10, 8'h20, 1'b0, 1'b1);
        check("poke_idle", 64'(busy), 64'(0));

        // Abort mid-operation with an asynchronous reset
        a = 8'h5A;
        b = 8'h3C;
        cin = 1'b1;
        start = 1'b1;
        exp_q.push_back({1'b0, 8'h5A} + {1'b0, 8'h3C} + 9'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_result = '0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_sum", 64'(sum), 64'(0));
        check("abort_cout", 64'(cout), 64'(0));
        a = 8'h01;
        b = 8'h01;
        cin = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", 64'(done), 64'(0));
        rst_n = 1'b1;
        run_add(8'h01, 8'h01, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_add(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        // start held high: accepts every W+2 edges, operands changing every cycle
        base = done_cnt;
        start = 1'b1;
        for (int j = 0; j < 5 * (W + 2); j++) begin
            if (j >= 1) check("hold_done", 64'(done), 64'(((j - 1) % (W + 2)) == W));
            a = 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
            if (j % (W + 2) == 0) exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
            @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("hold_done_count", 64'(done_cnt - base), 64'(5));
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
